tcdm_bank_arb: RTL and testbench

TCDM_BANK_ARB -- requirements
Module: tcdm_bank_arb

---
 rtl/tcdm_interconnect_pkg.sv | 16 +
 rtl/tcdm_bank_arb_chk.sv | 18 +
 rtl/tcdm_resp_pipe.sv | 35 +++
 rtl/tcdm_bank_arb.sv | 189 ++++++++++++++++++
 tb/tb_tcdm_bank_arb.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tcdm_interconnect_pkg.sv
// Shared types for the TCDM interconnect: the response-pipeline entry that carries
// a granted request's requester index and direction until its response returns.
package tcdm_interconnect_pkg;

    // Sized for the widest supported arbiter (32 requesters) so a single entry
    // type serves every NumIn; narrower arbiters leave the upper idx bits zero.
    localparam int MaxNumIn = 32;
    localparam int IdxWidth = $clog2(MaxNumIn);

    typedef struct packed {
        logic                valid;
        logic [IdxWidth-1:0] idx;
        logic                we_n;
    } resp_entry_t;

endpackage

// File: rtl/tcdm_bank_arb_chk.sv
// Simulation checks for tcdm_bank_arb: legal parameters and at most one grant per cycle.
module tcdm_bank_arb_chk #(
    parameter int NumIn   = 4,
    parameter int RespLat = 1,
    parameter int MaxWait = 8
) (
    input logic             clk_i,
    input logic             rst_ni,
    input logic [NumIn-1:0] gnt_o
);

    a_num_in_min:  assert property (@(posedge clk_i) NumIn >= 32'sd2);
    a_num_in_max:  assert property (@(posedge clk_i) NumIn <= 32'sd32);
    a_resp_lat:    assert property (@(posedge clk_i) RespLat >= 32'sd1);
    a_max_wait:    assert property (@(posedge clk_i) MaxWait >= 32'sd1);
    a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));

endmodule

// File: rtl/tcdm_resp_pipe.sv
// Fixed-depth delay line that returns each pushed entry exactly Depth cycles later.
// Reset empties every stage.
module tcdm_resp_pipe #(
    parameter int  Depth   = 1,
    parameter type entry_t = logic
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  entry_t in_i,
    output entry_t out_o
);

    entry_t [Depth-1:0] stage_d, stage_q;

    // Shift one stage per cycle; stage 0 takes the new entry.
    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = in_i;
        for (int i = 1; i < Depth; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_o = stage_q[Depth-1];

endmodule

// File: rtl/tcdm_bank_arb.sv
// Round-robin arbiter sharing one TCDM bank among NumIn requesters, with response routing.
// Define TCDM_BANK_ARB_STARVATION_GUARD_EN to add per-requester wait counters that force a grant.
module tcdm_bank_arb
    import tcdm_interconnect_pkg::*;
#(
    parameter int NumIn        = 4,
    parameter int AddrMemWidth = 12,
    parameter int DataWidth    = 32,
    parameter int BeWidth      = DataWidth / 8,
    parameter int RespLat      = 1,
    parameter int WriteRespOn  = 1,
    parameter int MaxWait      = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NumIn-1:0]                   req_i,
    input  logic [NumIn-1:0][AddrMemWidth-1:0] add_i,
    input  logic [NumIn-1:0]                   we_n_i,
    input  logic [NumIn-1:0][DataWidth-1:0]    wdata_i,
    input  logic [NumIn-1:0][BeWidth-1:0]      be_i,
    output logic [NumIn-1:0]                   gnt_o,
    output logic [NumIn-1:0]                   vld_o,
    output logic [NumIn-1:0][DataWidth-1:0]    rdata_o,
    output logic                               req_o,
    input  logic                               gnt_i,
    output logic [AddrMemWidth-1:0]            add_o,
    output logic                               we_n_o,
    output logic [DataWidth-1:0]               wdata_o,
    output logic [BeWidth-1:0]                 be_o,
    input  logic [DataWidth-1:0]               rdata_i
);

    localparam int PtrWidth = $clog2(NumIn);

    logic [PtrWidth-1:0] ptr_d, ptr_q;
    logic [PtrWidth-1:0] rr_idx, win_idx, cand, rsp_idx;
    logic                rr_vld, hit, hs;
    resp_entry_t         push_entry, pop_entry;

    // NumIn need not be a power of two, so wrap explicitly rather than by truncation.
    function automatic logic [PtrWidth-1:0] wrap_add(input logic [PtrWidth-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        return (sum >= NumIn) ? PtrWidth'(sum - NumIn) : PtrWidth'(sum);
    endfunction

    // First active request at or after ptr_q, wrapping past NumIn-1.
    always_comb begin
        rr_vld = 1'b0;
        rr_idx = '0;
        cand   = '0;
        hit    = 1'b0;
        for (int i = 0; i < NumIn; i++) begin
            cand   = wrap_add(ptr_q, i);
            hit    = !rr_vld && req_i[cand];
            rr_idx = hit ? cand : rr_idx;
            rr_vld = rr_vld | hit;
        end
    end

`ifdef TCDM_BANK_ARB_STARVATION_GUARD_EN
    localparam int WaitWidth = $clog2(MaxWait + 1);

    logic [NumIn-1:0][WaitWidth-1:0] wait_d, wait_q;
    logic                            starve_vld;
    logic [PtrWidth-1:0]             starve_idx;

    // Lowest-index saturated counter overrides round-robin; downward scan keeps the lowest.
    always_comb begin
        starve_vld = 1'b0;
        starve_idx = '0;
        for (int i = NumIn - 1; i >= 0; i--) begin
            starve_idx = (wait_q[i] == WaitWidth'(MaxWait)) ? PtrWidth'(i) : starve_idx;
            starve_vld = starve_vld | (wait_q[i] == WaitWidth'(MaxWait));
        end
    end

    // Count cycles spent requesting without a grant, saturating at MaxWait.
    always_comb begin
        wait_d = '0;
        for (int i = 0; i < NumIn; i++) begin
            if (req_i[i] && !gnt_o[i]) begin
                wait_d[i] = (wait_q[i] == WaitWidth'(MaxWait)) ? wait_q[i] : wait_q[i] + WaitWidth'(1);
            end else begin
                wait_d[i] = '0;
            end
        end
    end

    // Wait counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    assign win_idx = starve_vld ? starve_idx : rr_idx;
`else
    assign win_idx = rr_idx;
`endif

    assign req_o = |req_i;
    assign hs    = req_o & gnt_i;

    // Forward the winner's request to the bank and reflect the bank grant back.
    always_comb begin
        gnt_o   = '0;
        add_o   = '0;
        we_n_o  = 1'b0;
        wdata_o = '0;
        be_o    = '0;
        if (req_o) begin
            gnt_o[win_idx] = gnt_i;
            add_o          = add_i[win_idx];
            we_n_o         = we_n_i[win_idx];
            wdata_o        = wdata_i[win_idx];
            be_o           = be_i[win_idx];
        end else begin
            gnt_o = '0;
        end
    end

    // Priority moves just past the winner only when the bank accepts.
    always_comb begin
        if (hs) begin
            ptr_d = (win_idx == PtrWidth'(NumIn - 1)) ? '0 : win_idx + PtrWidth'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Record every accepted request so its response can be routed back.
    always_comb begin
        push_entry = '0;
        if (hs) begin
            push_entry.valid = 1'b1;
            push_entry.idx   = IdxWidth'(win_idx);
            push_entry.we_n  = we_n_o;
        end else begin
            push_entry = '0;
        end
    end

    tcdm_resp_pipe #(
        .Depth   (RespLat),
        .entry_t (resp_entry_t)
    ) i_resp_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .in_i   (push_entry),
        .out_o  (pop_entry)
    );

    assign rsp_idx = PtrWidth'(pop_entry.idx);

    // Route the bank response to its requester; stores respond only when enabled.
    always_comb begin
        vld_o   = '0;
        rdata_o = '0;
        if (pop_entry.valid && (pop_entry.we_n || (WriteRespOn != 0))) begin
            vld_o[rsp_idx]   = 1'b1;
            rdata_o[rsp_idx] = rdata_i;
        end else begin
            vld_o = '0;
        end
    end

    tcdm_bank_arb_chk #(
        .NumIn   (NumIn),
        .RespLat (RespLat),
        .MaxWait (MaxWait)
    ) i_chk (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .gnt_o  (gnt_o)
    );

endmodule

// File: tb/tb_tcdm_bank_arb.sv
// Bench for tcdm_bank_arb: dut_a uses defaults, dut_b uses RespLat=3, WriteRespOn=0, MaxWait=2.
// Honours TCDM_BANK_ARB_STARVATION_GUARD_EN when the design is built with it.
module tb_tcdm_bank_arb;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] we_n = '1;
    logic gnt = 1'b0;
    logic [N-1:0][11:0] add = '0;
    logic [N-1:0][31:0] wdata = '0;
    logic [N-1:0][3:0] be = '0;
    logic [31:0] rdata = '0;

    logic req_o_a, we_n_o_a, req_o_b, we_n_o_b;
    logic [N-1:0] gnt_o_a, vld_o_a, gnt_o_b, vld_o_b;
    logic [N-1:0][31:0] rdata_o_a, rdata_o_b;
    logic [11:0] add_o_a, add_o_b;
    logic [31:0] wdata_o_a, wdata_o_b;
    logic [3:0] be_o_a, be_o_b;

    always #5 clk = ~clk;

    tcdm_bank_arb dut_a (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .add_i(add), .we_n_i(we_n),
        .wdata_i(wdata), .be_i(be), .gnt_o(gnt_o_a), .vld_o(vld_o_a), .rdata_o(rdata_o_a),
        .req_o(req_o_a), .gnt_i(gnt), .add_o(add_o_a), .we_n_o(we_n_o_a),
        .wdata_o(wdata_o_a), .be_o(be_o_a), .rdata_i(rdata)
    );

    tcdm_bank_arb #(.RespLat(3), .WriteRespOn(0), .MaxWait(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .add_i(add), .we_n_i(we_n),
        .wdata_i(wdata), .be_i(be), .gnt_o(gnt_o_b), .vld_o(vld_o_b), .rdata_o(rdata_o_b),
        .req_o(req_o_b), .gnt_i(gnt), .add_o(add_o_b), .we_n_o(we_n_o_b),
        .wdata_o(wdata_o_b), .be_o(be_o_b), .rdata_i(rdata)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct { int dut; int due; int idx; } rsp_t;
    rsp_t rsp_q[$];
    int m_ptr[2];
    int m_wait[2][N];
    int cyc = 0;

    function automatic int lat_of(int d); return (d == 0) ? 1 : 3; endfunction
    function automatic int wro_of(int d); return (d == 0) ? 1 : 0; endfunction
    function automatic int mw_of(int d);  return (d == 0) ? 8 : 2; endfunction

    function automatic int model_winner(int d);
        int w = -1;
`ifdef TCDM_BANK_ARB_STARVATION_GUARD_EN
        for (int k = 0; k < N; k++)
            if (w < 0 && req[k] && m_wait[d][k] == mw_of(d)) w = k;
`endif
        for (int i = 0; i < N; i++)
            if (w < 0 && req[(m_ptr[d] + i) % N]) w = (m_ptr[d] + i) % N;
        return w;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0;
            for (int k = 0; k < N; k++) m_wait[d][k] = 0;
        end
        rsp_q.delete();
    endtask

    task automatic model_step();
        rsp_t keep[$];
        for (int d = 0; d < 2; d++) begin
            int w;
            bit h;
            rsp_t e;
            w = model_winner(d);
            h = (w >= 0) && gnt;
            if (h) begin
                m_ptr[d] = (w + 1) % N;
                if (we_n[w] || wro_of(d) == 1) begin
                    e.dut = d; e.due = cyc + lat_of(d); e.idx = w;
                    rsp_q.push_back(e);
                end
            end
            for (int k = 0; k < N; k++) begin
                if (req[k] && !(h && w == k))
                    m_wait[d][k] = (m_wait[d][k] + 1 > mw_of(d)) ? mw_of(d) : m_wait[d][k] + 1;
                else
                    m_wait[d][k] = 0;
            end
        end
        cyc++;
        foreach (rsp_q[i]) if (rsp_q[i].due >= cyc) keep.push_back(rsp_q[i]);
        rsp_q = keep;
    endtask

    task automatic check_model();
        for (int d = 0; d < 2; d++) begin
            int w;
            string s;
            logic [N-1:0] eg, ev, ag, av;
            logic [N-1:0][31:0] er, ar;
            logic [11:0] ea;
            logic ew;
            logic [31:0] ed;
            logic [3:0] eb;
            w = model_winner(d);
            eg = '0; ev = '0; er = '0; ea = '0; ew = 1'b0; ed = '0; eb = '0;
            if (w >= 0) begin
                ea = add[w]; ew = we_n[w]; ed = wdata[w]; eb = be[w]; eg[w] = gnt;
            end
            foreach (rsp_q[i]) if (rsp_q[i].dut == d && rsp_q[i].due == cyc) ev[rsp_q[i].idx] = 1'b1;
            for (int k = 0; k < N; k++) if (ev[k]) er[k] = rdata;
            s  = (d == 0) ? "a" : "b";
            ag = (d == 0) ? gnt_o_a : gnt_o_b;
            av = (d == 0) ? vld_o_a : vld_o_b;
            ar = (d == 0) ? rdata_o_a : rdata_o_b;
            chk($sformatf("rnd_gnt_%s", s), 128'(ag), 128'(eg));
            chk($sformatf("rnd_vld_%s", s), 128'(av), 128'(ev));
            chk($sformatf("rnd_rdata_%s", s), 128'(ar), 128'(er));
            chk($sformatf("rnd_req_%s", s), 128'((d == 0) ? req_o_a : req_o_b), 128'(|req));
            chk($sformatf("rnd_add_%s", s), 128'((d == 0) ? add_o_a : add_o_b), 128'(ea));
            chk($sformatf("rnd_we_%s", s), 128'((d == 0) ? we_n_o_a : we_n_o_b), 128'(ew));
            chk($sformatf("rnd_wdata_%s", s), 128'((d == 0) ? wdata_o_a : wdata_o_b), 128'(ed));
            chk($sformatf("rnd_be_%s", s), 128'((d == 0) ? be_o_a : be_o_b), 128'(eb));
        end
    endtask

    // ---------------- directed helpers ----------------
    task automatic apply(input logic [N-1:0] r, input logic [N-1:0] w, input logic g, input logic [31:0] rd);
        @(negedge clk);
        req = r; we_n = w; gnt = g; rdata = rd;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0; req = '0; gnt = 1'b0;
        #1;
        chk("rst_vld_a", 128'(vld_o_a), 128'(0));
        chk("rst_rdata_a", 128'(rdata_o_a), 128'(0));
        chk("rst_vld_b", 128'(vld_o_b), 128'(0));
        chk("rst_rdata_b", 128'(rdata_o_b), 128'(0));
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic         gnt;
        logic [N-1:0] exp_gnt;
        int           exp_win;
        logic [N-1:0] exp_vld;
    } vec_t;

    vec_t vecs[20];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 0,  4'b0000};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1,  4'b0001};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 2,  4'b0010};
        vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 3,  4'b0100};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 0,  4'b1000};
        vecs[5]  = '{4'b1111, 1'b1, 4'b0010, 1,  4'b0001};
        vecs[6]  = '{4'b1111, 1'b1, 4'b0100, 2,  4'b0010};
        vecs[7]  = '{4'b1111, 1'b1, 4'b1000, 3,  4'b0100};
        vecs[8]  = '{4'b0000, 1'b1, 4'b0000, -1, 4'b1000};
        vecs[9]  = '{4'b1010, 1'b1, 4'b0010, 1,  4'b0000};
        vecs[10] = '{4'b1010, 1'b1, 4'b1000, 3,  4'b0010};
        vecs[11] = '{4'b0000, 1'b0, 4'b0000, -1, 4'b1000};
        for (int i = 12; i < 17; i++) vecs[i] = '{4'b0110, 1'b0, 4'b0000, 1, 4'b0000};
        vecs[17] = '{4'b0110, 1'b1, 4'b0010, 1,  4'b0000};
        vecs[18] = '{4'b0110, 1'b1, 4'b0100, 2,  4'b0010};
        vecs[19] = '{4'b0000, 1'b0, 4'b0000, -1, 4'b0100};

        for (int k = 0; k < N; k++) begin
            add[k] = 12'h100 + 12'(k);
            wdata[k] = 32'h1111_0000 + 32'(k);
            be[k] = 4'hF;
        end

        // Table: round-robin order, wrap from sparse requests, parked bank.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            logic [11:0] ea;
            logic [N-1:0][31:0] er;
            apply(vecs[i].req, 4'b1111, vecs[i].gnt, 32'hC0DE_0000 + 32'(i));
            ea = (vecs[i].exp_win >= 0) ? 12'(12'h100 + vecs[i].exp_win) : 12'h000;
            er = '0;
            for (int k = 0; k < N; k++) if (vecs[i].exp_vld[k]) er[k] = rdata;
            chk($sformatf("tbl%0d_gnt", i), 128'(gnt_o_a), 128'(vecs[i].exp_gnt));
            chk($sformatf("tbl%0d_vld", i), 128'(vld_o_a), 128'(vecs[i].exp_vld));
            chk($sformatf("tbl%0d_req", i), 128'(req_o_a), 128'(|vecs[i].req));
            chk($sformatf("tbl%0d_add", i), 128'(add_o_a), 128'(ea));
            chk($sformatf("tbl%0d_rdata", i), 128'(rdata_o_a), 128'(er));
        end

        // Store from requester 2: response only where writes respond.
        do_reset();
        apply(4'b0100, 4'b1011, 1'b1, 32'h0);
        chk("st_gnt_a", 128'(gnt_o_a), 128'(4'b0100));
        chk("st_we_a", 128'(we_n_o_a), 128'(0));
        apply(4'b0000, 4'b1111, 1'b0, 32'h5A5A_0002);
        chk("st_vld_a", 128'(vld_o_a), 128'(4'b0100));
        chk("st_rdata_a", 128'(rdata_o_a[2]), 128'(32'h5A5A_0002));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("st_vld_b%0d", i), 128'(vld_o_b), 128'(0));
            apply(4'b0000, 4'b1111, 1'b0, 32'h0);
        end

        // Two reads, RespLat=3: responses three cycles later in order.
        do_reset();
        apply(4'b0010, 4'b1111, 1'b1, 32'h0);
        chk("l3_gnt0_b", 128'(gnt_o_b), 128'(4'b0010));
        apply(4'b1000, 4'b1111, 1'b1, 32'h0);
        chk("l3_gnt1_b", 128'(gnt_o_b), 128'(4'b1000));
        apply(4'b0000, 4'b1111, 1'b0, 32'h0);
        chk("l3_vld2_b", 128'(vld_o_b), 128'(0));
        apply(4'b0000, 4'b1111, 1'b0, 32'hA5A5_0001);
        chk("l3_vld3_b", 128'(vld_o_b), 128'(4'b0010));
        chk("l3_rdata3_b", 128'(rdata_o_b[1]), 128'(32'hA5A5_0001));
        apply(4'b0000, 4'b1111, 1'b0, 32'hA5A5_0003);
        chk("l3_vld4_b", 128'(vld_o_b), 128'(4'b1000));
        chk("l3_rdata4_b", 128'(rdata_o_b[3]), 128'(32'hA5A5_0003));

        // Reset right after a handshake discards the in-flight response.
        do_reset();
        apply(4'b0001, 4'b1111, 1'b1, 32'h0);
        @(negedge clk);
        rst_ni = 1'b0; req = '0; gnt = 1'b0;
        #1;
        chk("rr_vld_a_in_rst", 128'(vld_o_a), 128'(0));
        @(negedge clk);
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            apply(4'b0000, 4'b1111, 1'b0, 32'hFFFF_FFFF);
            chk($sformatf("rr_vld_a%0d", i), 128'(vld_o_a), 128'(0));
            chk($sformatf("rr_vld_b%0d", i), 128'(vld_o_b), 128'(0));
        end

        // Requester 3 waits while the bank is parked, then others join.
        do_reset();
        apply(4'b1000, 4'b1111, 1'b0, 32'h0);
        chk("sv_gnt0_b", 128'(gnt_o_b), 128'(0));
        apply(4'b1011, 4'b1111, 1'b0, 32'h0);
        chk("sv_gnt1_b", 128'(gnt_o_b), 128'(0));
        apply(4'b1011, 4'b1111, 1'b1, 32'h0);
        chk("sv_gnt2_a", 128'(gnt_o_a), 128'(4'b0001));
`ifdef TCDM_BANK_ARB_STARVATION_GUARD_EN
        chk("sv_gnt2_b", 128'(gnt_o_b), 128'(4'b1000));
`else
        chk("sv_gnt2_b", 128'(gnt_o_b), 128'(4'b0001));
`endif

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rst_ni = ($urandom_range(0, 99) != 0);
            req = 4'($urandom);
            we_n = 4'($urandom);
            gnt = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) begin
                add[k] = 12'($urandom);
                wdata[k] = $urandom;
                be[k] = 4'($urandom);
            end
            rdata = $urandom;
            #1;
            if (rst_ni) begin
                check_model();
            end else begin
                chk("rnd_rst_vld_a", 128'(vld_o_a), 128'(0));
                chk("rnd_rst_vld_b", 128'(vld_o_b), 128'(0));
            end
            @(posedge clk);
            if (rst_ni) model_step();
            else model_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
